// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues word reads to the instruction memory,
// holds one returned word for decode, and handles redirects and halt.
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h00000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  output logic [31:0] ins_npc,
  output logic        ins_valid,
  input  logic        ins_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    FULL   = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      state, state_d;
  logic [31:0] pc, pc_d;
  logic [31:0] pc_next, pc_next_d;
  logic        drop, drop_d;
  logic [31:0] ins_d, ins_pc_d, ins_npc_d;
  logic        ins_valid_d;
  logic        complete;
  logic [31:0] target;

  // A request is outstanding in FETCH and DRAIN; iaddr always mirrors pc so
  // it cannot move mid-request (pc only changes at completion or outside them).
  assign iREN     = (state == FETCH) || (state == DRAIN);
  assign iaddr    = pc;
  assign complete = iREN && !iwait;
  assign target   = {redirect_pc[31:2], 2'b00};
  assign halted   = (state == HALTED);

  // State register and datapath registers; reset wins over everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= FETCH;
      pc        <= PC_INIT;
      pc_next   <= 32'h0;
      drop      <= 1'b0;
      ins       <= 32'h0;
      ins_pc    <= 32'h0;
      ins_npc   <= 32'h0;
      ins_valid <= 1'b0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      pc_next   <= pc_next_d;
      drop      <= drop_d;
      ins       <= ins_d;
      ins_pc    <= ins_pc_d;
      ins_npc   <= ins_npc_d;
      ins_valid <= ins_valid_d;
    end
  end

  // Next-state logic: halt beats redirect, redirect squashes the buffer and
  // any in-flight word, otherwise fetch/hold/consume in sequence.
  always_comb begin
    state_d     = state;
    pc_d        = pc;
    pc_next_d   = pc_next;
    drop_d      = drop;
    ins_d       = ins;
    ins_pc_d    = ins_pc;
    ins_npc_d   = ins_npc;
    ins_valid_d = ins_valid;

    if (halt && state != HALTED) begin
      ins_valid_d = 1'b0;
      drop_d      = 1'b0;
      if (iREN && !complete) begin
        state_d = DRAIN;
      end else begin
        state_d = HALTED;
      end
    end else begin
      case (state)
        FETCH: begin
          if (redirect) begin
            ins_valid_d = 1'b0;
            if (complete) begin
              pc_d   = target;
              drop_d = 1'b0;
            end else begin
              pc_next_d = target;
              drop_d    = 1'b1;
            end
          end else if (complete) begin
            if (drop) begin
              drop_d = 1'b0;
              pc_d   = pc_next;
            end else begin
              ins_d       = iload;
              ins_pc_d    = pc;
              ins_npc_d   = pc + 32'd4;
              ins_valid_d = 1'b1;
              pc_d        = pc + 32'd4;
              state_d     = FULL;
            end
          end
        end
        FULL: begin
          if (redirect) begin
            ins_valid_d = 1'b0;
            pc_d        = target;
            state_d     = FETCH;
          end else if (ins_valid && ins_ready) begin
            ins_valid_d = 1'b0;
            state_d     = FETCH;
          end
        end
        DRAIN: begin
          ins_valid_d = 1'b0;
          if (complete) begin
            state_d = HALTED;
          end
        end
        HALTED: begin
          ins_valid_d = 1'b0;
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances share stimulus, one reset to
// address 0 and one reset to the top word of the address space.
module tb_fetch_unit;

  logic        CLK;
  logic        RST;
  logic        iwait;
  logic [31:0] iload;
  logic        ins_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;

  logic        iren_a, ins_valid_a, halted_a;
  logic [31:0] iaddr_a, ins_a, ins_pc_a, ins_npc_a;
  logic        iren_b, ins_valid_b, halted_b;
  logic [31:0] iaddr_b, ins_b, ins_pc_b, ins_npc_b;

  int passed = 0;
  int total  = 0;

  fetch_unit #(.PC_INIT(32'h00000000)) u_a (
    .CLK(CLK), .RST(RST), .iwait(iwait), .iload(iload),
    .iREN(iren_a), .iaddr(iaddr_a), .ins(ins_a), .ins_pc(ins_pc_a),
    .ins_npc(ins_npc_a), .ins_valid(ins_valid_a), .ins_ready(ins_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .halted(halted_a)
  );

  fetch_unit #(.PC_INIT(32'hFFFFFFFC)) u_b (
    .CLK(CLK), .RST(RST), .iwait(iwait), .iload(iload),
    .iREN(iren_b), .iaddr(iaddr_b), .ins(ins_b), .ins_pc(ins_pc_b),
    .ins_npc(ins_npc_b), .ins_valid(ins_valid_b), .ins_ready(ins_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .halted(halted_b)
  );

  // Memory returns a recognisable word derived from the address of instance A.
  assign iload = 32'hA0000000 | iaddr_a;

  // Free-running clock.
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic rst_v, input logic iwait_v,
                               input logic ready_v, input logic redir_v,
                               input logic [31:0] rpc_v, input logic halt_v);
    RST         = rst_v;
    iwait       = iwait_v;
    ins_ready   = ready_v;
    redirect    = redir_v;
    redirect_pc = rpc_v;
    halt        = halt_v;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) begin
      passed++;
    end else begin
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Directed sequence of steps with hand-computed expectations.
  initial begin
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    tick();

    // Reset state
    checkOutput("rst_valid", {31'h0, ins_valid_a}, 32'h0);
    checkOutput("rst_halted", {31'h0, halted_a}, 32'h0);
    checkOutput("rst_iaddr", iaddr_a, 32'h0);
    checkOutput("rst_ins", ins_a, 32'h0);
    checkOutput("rst_ins_pc", ins_pc_a, 32'h0);
    checkOutput("rst_iren", {31'h0, iren_a}, 32'h1);
    checkOutput("rst_b_iaddr", iaddr_b, 32'hFFFFFFFC);

    // Zero-wait streaming, one instruction every two cycles
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("s0_iaddr", iaddr_a, 32'h0);
    tick();
    checkOutput("s0_valid", {31'h0, ins_valid_a}, 32'h1);
    checkOutput("s0_ins", ins_a, 32'hA0000000);
    checkOutput("s0_pc", ins_pc_a, 32'h0);
    checkOutput("s0_npc", ins_npc_a, 32'h4);
    checkOutput("s0_iren", {31'h0, iren_a}, 32'h0);
    tick();
    checkOutput("s1_valid_gap", {31'h0, ins_valid_a}, 32'h0);
    checkOutput("s1_iaddr", iaddr_a, 32'h4);
    tick();
    checkOutput("s1_ins", ins_a, 32'hA0000004);
    checkOutput("s1_pc", ins_pc_a, 32'h4);
    checkOutput("s1_npc", ins_npc_a, 32'h8);
    tick();
    checkOutput("s2_iaddr", iaddr_a, 32'h8);
    tick();
    checkOutput("s2_pc", ins_pc_a, 32'h8);
    checkOutput("s2_npc", ins_npc_a, 32'hC);

    // Decode stalls five cycles while the buffer is full
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("stall_iren", {31'h0, iren_a}, 32'h0);
      checkOutput("stall_pc", ins_pc_a, 32'h8);
      checkOutput("stall_ins", ins_a, 32'hA0000008);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("unstall_iren", {31'h0, iren_a}, 32'h1);
    checkOutput("unstall_iaddr", iaddr_a, 32'hC);
    tick();
    tick();
    checkOutput("pre_wait_iaddr", iaddr_a, 32'h10);

    // Three wait cycles at 0x10
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("wait_iren", {31'h0, iren_a}, 32'h1);
      checkOutput("wait_iaddr", iaddr_a, 32'h10);
      checkOutput("wait_valid", {31'h0, ins_valid_a}, 32'h0);
      tick();
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("wait_last_iaddr", iaddr_a, 32'h10);
    tick();
    checkOutput("wait_done_valid", {31'h0, ins_valid_a}, 32'h1);
    checkOutput("wait_done_pc", ins_pc_a, 32'h10);
    checkOutput("wait_done_ins", ins_a, 32'hA0000010);
    tick();
    checkOutput("next_iaddr", iaddr_a, 32'h14);

    // Redirect during a completing zero-wait fetch: word dropped, go to 0x20
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 1'b0);
    tick();
    checkOutput("redir_now_valid", {31'h0, ins_valid_a}, 32'h0);
    checkOutput("redir_now_iaddr", iaddr_a, 32'h20);

    // Redirect to 0x103 in the first cycle of a three-wait fetch at 0x20
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 32'h103, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("redir_hold_iaddr", iaddr_a, 32'h20);
    checkOutput("redir_hold_iren", {31'h0, iren_a}, 32'h1);
    tick();
    checkOutput("redir_hold2_iaddr", iaddr_a, 32'h20);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("redir_drop_valid", {31'h0, ins_valid_a}, 32'h0);
    checkOutput("redir_new_iaddr", iaddr_a, 32'h100);
    checkOutput("redir_new_iren", {31'h0, iren_a}, 32'h1);
    tick();
    checkOutput("redir_ins_valid", {31'h0, ins_valid_a}, 32'h1);
    checkOutput("redir_ins_pc", ins_pc_a, 32'h100);
    checkOutput("redir_ins", ins_a, 32'hA0000100);
    tick();
    checkOutput("pre_halt_iaddr", iaddr_a, 32'h104);

    // Halt while a request is waiting: drain it, then stop
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("drain_iren", {31'h0, iren_a}, 32'h1);
    checkOutput("drain_iaddr", iaddr_a, 32'h104);
    checkOutput("drain_halted", {31'h0, halted_a}, 32'h0);
    tick();
    checkOutput("drain2_iren", {31'h0, iren_a}, 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("halt_halted", {31'h0, halted_a}, 32'h1);
    checkOutput("halt_valid", {31'h0, ins_valid_a}, 32'h0);
    for (int i = 0; i < 20; i++) begin
      checkOutput("halt_iren", {31'h0, iren_a}, 32'h0);
      tick();
    end
    checkOutput("halt_stay", {31'h0, halted_a}, 32'h1);

    // Halt and redirect together: halt wins, no redirect fetch
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("hr_halted", {31'h0, halted_a}, 32'h1);
    checkOutput("hr_iren", {31'h0, iren_a}, 32'h0);
    checkOutput("hr_iaddr", iaddr_a, 32'h0);
    checkOutput("hr_valid", {31'h0, ins_valid_a}, 32'h0);
    tick();
    checkOutput("hr_iren2", {31'h0, iren_a}, 32'h0);

    // PC wraps from 0xFFFFFFFC to 0
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("wrap_rst_iaddr", iaddr_b, 32'hFFFFFFFC);
    checkOutput("wrap_rst_halted", {31'h0, halted_b}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    tick();
    checkOutput("wrap_ins_pc", ins_pc_b, 32'hFFFFFFFC);
    checkOutput("wrap_ins_npc", ins_npc_b, 32'h0);
    tick();
    checkOutput("wrap_iaddr", iaddr_b, 32'h0);
    checkOutput("wrap_iren", {31'h0, iren_b}, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Front end of the pipeline. Supplies the instruction word that the decode unit consumes.
- Issues word reads to the instruction-memory port and holds each returned word in a one-entry output buffer until decode accepts it.
- Applies PC redirects (branches, jumps, jr) and halt from downstream.
- Discards in-flight words made stale by a redirect.

Parameters:
PC_INIT, 32'h00000000, PC after reset (word aligned)

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  synchronous, active-high reset
iwait  input  1  memory busy; a request completes in a cycle with iREN=1 and iwait=0
iload  input  32  instruction word, valid in the completion cycle
iREN  output  1  read request
iaddr  output  32  request address (current pc)
ins  output  32  buffered instruction (to decode unit ins)
ins_pc  output  32  address of ins
ins_npc  output  32  ins_pc+4
ins_valid  output  1  buffer holds an instruction
ins_ready  input  1  decode accepts ins this cycle (consumed when ins_valid & ins_ready)
redirect  input  1  squash and restart fetch at redirect_pc
redirect_pc  input  32  new fetch address; bits [1:0] forced to 0
halt  input  1  stop fetching (decode halt)
halted  output  1  fetch stopped

Behaviour:
- States: FETCH, FULL, DRAIN, HALTED. Internal registers: pc, drop flag, output buffer.
- Reset (RST=1 at edge):
  - state=FETCH, pc=PC_INIT, drop=0.
  - ins=0, ins_pc=0, ins_npc=0, ins_valid=0, halted=0.
  - Reset overrides every other input. Reset mid-request abandons it; the memory side must tolerate the dropped request.
- iREN=1 only in FETCH and DRAIN. iaddr=pc at all times.
- Once iREN rises, iREN and iaddr stay constant until completion. A redirect never changes iaddr mid-request; pc updates only at completion or outside FETCH/DRAIN.
- Completion: iREN & !iwait. Zero-wait memory completes in the issuing cycle.
- FETCH:
  - On completion with drop=0: buffer<=iload, ins_pc<=pc, ins_npc<=pc+4, ins_valid<=1, pc<=pc+4, state→FULL.
  - On completion with drop=1: word discarded, drop<=0, pc<=redirect target latched in pc_next (see redirect), stay FETCH.
- FULL:
  - iREN=0.
  - On ins_valid & ins_ready: ins_valid<=0, state→FETCH.
  - Steady-state throughput with zero-wait memory is one instruction per 2 cycles.
- Redirect (redirect=1, not halt, not RST):
  - ins_valid<=0; ins_ready is ignored that cycle because the buffered word is squashed.
  - In FULL: pc<=redirect_pc&~3, state→FETCH.
  - In FETCH, completing this cycle: word discarded, pc<=target, stay FETCH.
  - In FETCH, not completing: target stored in pc_next, drop<=1. At completion pc<=pc_next.
  - A second redirect while drop=1 overwrites pc_next; the last target wins.
- Halt (halt=1) has priority over redirect:
  - ins_valid<=0, drop<=0.
  - If a request is outstanding and not completing this cycle: state→DRAIN, keep iREN until completion, discard the word, then HALTED.
  - Otherwise state→HALTED directly.
- HALTED: iREN=0, halted=1, ins_valid=0. Only RST exits.
- Arithmetic: pc+4 is modulo 2^32; 32'hFFFFFFFC+4=0.

Test Plan:
- Reset with PC_INIT=0, iwait=0, ins_ready=1 → iaddr sequence 0,4,8; ins_valid high every other cycle; ins/ins_pc/ins_npc match iload/0/4, then 4/8, then 8/12.
- iwait held high 3 cycles at pc=0x10 → iREN=1 and iaddr=0x10 stable for 4 cycles; ins_valid rises only after completion.
- ins_ready=0 for 5 cycles while FULL → iREN=0, ins/ins_pc unchanged; the next request (pc+4) issues the cycle after ins_ready=1.
- redirect to 0x103 at cycle 1 of a 3-wait fetch at 0x20 → word for 0x20 never reaches ins_valid; next iaddr=0x100; ins_pc=0x100.
- halt during an outstanding request with iwait=1 → iREN held until completion, word discarded, halted=1 afterwards, iREN stays 0 for 20 cycles; halt+redirect in the same cycle → halted, no redirect fetch.
- PC_INIT=32'hFFFFFFFC, zero wait → first ins_npc=0, second iaddr=0.
